ddc_cfg_ctrl: RTL and testbench

DDC_CFG_CTRL -- requirements
Module: ddc_cfg_ctrl

---
 rtl/ddc_ctrl_pkg.sv | 18 +
 rtl/ddc_coeff_bank.sv | 33 +++
 rtl/ddc_cfg_ctrl.sv | 137 +++++++++++++
 tb/tb_ddc_cfg_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddc_ctrl_pkg.sv
// rtl/ddc_ctrl_pkg.sv - shared types and constants for the DDC coefficient config controller
package ddc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWAP  = 2'd2
  } ddc_state_e;

  // Config address layout: [7:6] stage, [5:0] coefficient index.
  localparam int STAGE_W = 2;
  localparam int IDX_W   = 6;
  localparam int ADDR_W  = STAGE_W + IDX_W;

  // Each stage bypass bit resets to pass-through.
  localparam logic BYPASS_RST_BIT = 1'b1;

endpackage

// File: rtl/ddc_coeff_bank.sv
// rtl/ddc_coeff_bank.sv - shadow/active coefficient register pair for one decimator stage
module ddc_coeff_bank
  import ddc_ctrl_pkg::*;
#(
  parameter int COEFF_WIDTH = 16,
  parameter int N_COEFFS    = 40
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   wr_en_i,
  input  logic [IDX_W-1:0]                       wr_idx_i,
  input  logic [COEFF_WIDTH-1:0]                 wr_data_i,
  input  logic                                   swap_i,
  output logic [N_COEFFS-1:0][COEFF_WIDTH-1:0]   active_o
);

  logic [N_COEFFS-1:0][COEFF_WIDTH-1:0] shadow_q;
  logic [N_COEFFS-1:0][COEFF_WIDTH-1:0] active_q;

  // Config writes land in shadow; a swap copies the whole shadow into active at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (wr_en_i) shadow_q[wr_idx_i] <= wr_data_i;
      if (swap_i)  active_q <= shadow_q;
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/ddc_cfg_ctrl.sv
// rtl/ddc_cfg_ctrl.sv - double-buffered coefficient config controller with drain-then-swap sequencing
`ifndef COEFF_WIDTH
`define COEFF_WIDTH 16
`endif

module ddc_cfg_ctrl
  import ddc_ctrl_pkg::*;
#(
  parameter int COEFF_WIDTH  = `COEFF_WIDTH,
  parameter int N_COEFFS     = 40,
  parameter int N_STAGES     = 3,
  parameter int DRAIN_CYCLES = 64
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 cfg_valid_in,
  output logic                                                 cfg_ready_out,
  input  logic                                                 cfg_commit_in,
  input  logic [ADDR_W-1:0]                                    cfg_addr_in,
  input  logic [COEFF_WIDTH-1:0]                               cfg_data_in,
  input  logic [N_STAGES-1:0]                                  cfg_bypass_in,
  output logic [N_STAGES-1:0][N_COEFFS-1:0][COEFF_WIDTH-1:0]   coeffs_out,
  output logic [N_STAGES-1:0]                                  bypass_out,
  output logic                                                 gate_out,
  output logic                                                 busy_out,
  output logic                                                 done_out,
  output logic                                                 err_out
);

  generate
    if (DRAIN_CYCLES < 1) begin : g_bad_drain
      $error("ddc_cfg_ctrl: DRAIN_CYCLES must be at least 1");
    end
  endgenerate

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  ddc_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [N_STAGES-1:0] pend_q;
  logic [N_STAGES-1:0] bypass_q;
  logic                ready_q;
  logic                gate_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  logic                stage_ok;
  logic                idx_ok;
  logic                write_ok;
  logic                accept;
  logic                swap;

  assign accept   = (state_q == ST_IDLE) && cfg_valid_in;
  assign stage_ok = int'(cfg_addr_in[ADDR_W-1:IDX_W]) < N_STAGES;
  assign idx_ok   = int'(cfg_addr_in[IDX_W-1:0]) < N_COEFFS;
  assign write_ok = accept && !cfg_commit_in && stage_ok && idx_ok;
  assign swap     = (state_q == ST_SWAP);

  // Sequencer: accept config in IDLE, hold the datapath gated through DRAIN, swap banks, then pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pend_q   <= {N_STAGES{BYPASS_RST_BIT}};
      bypass_q <= {N_STAGES{BYPASS_RST_BIT}};
      ready_q  <= 1'b1;
      gate_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (cfg_commit_in) begin
              pend_q  <= cfg_bypass_in;
              err_q   <= 1'b0;
              cnt_q   <= CNT_W'(DRAIN_CYCLES - 1);
              state_q <= ST_DRAIN;
              ready_q <= 1'b0;
              gate_q  <= 1'b1;
              busy_q  <= 1'b1;
            end else if (!(stage_ok && idx_ok)) begin
              err_q <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (cnt_q == '0) state_q <= ST_SWAP;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        ST_SWAP: begin
          bypass_q <= pend_q;
          state_q  <= ST_IDLE;
          ready_q  <= 1'b1;
          gate_q   <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          gate_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  genvar s;
  generate
    for (s = 0; s < N_STAGES; s++) begin : g_bank
      ddc_coeff_bank #(
        .COEFF_WIDTH (COEFF_WIDTH),
        .N_COEFFS    (N_COEFFS)
      ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (write_ok && (cfg_addr_in[ADDR_W-1:IDX_W] == STAGE_W'(s))),
        .wr_idx_i  (cfg_addr_in[IDX_W-1:0]),
        .wr_data_i (cfg_data_in),
        .swap_i    (swap),
        .active_o  (coeffs_out[s])
      );
    end
  endgenerate

  assign cfg_ready_out = ready_q;
  assign bypass_out    = bypass_q;
  assign gate_out      = gate_q;
  assign busy_out      = busy_q;
  assign done_out      = done_q;
  assign err_out       = err_q;

endmodule

// File: tb/tb_ddc_cfg_ctrl.sv
// tb/tb_ddc_cfg_ctrl.sv - scoreboard bench for ddc_cfg_ctrl
module tb_ddc_cfg_ctrl;

  localparam int CW = 16;
  localparam int NC = 40;
  localparam int NS = 3;
  localparam int DC = 64;

  typedef logic [NS-1:0][NC-1:0][CW-1:0] coeffs_t;
  typedef struct packed {
    coeffs_t         c;
    logic [NS-1:0]   b;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_commit = 1'b0;
  logic [7:0]    cfg_addr = '0;
  logic [CW-1:0] cfg_data = '0;
  logic [NS-1:0] cfg_bypass = '0;
  logic          ready, gate, busy, done, err;
  coeffs_t       coeffs;
  logic [NS-1:0] bypass;

  logic          v2 = 1'b0;
  logic          c2 = 1'b0;
  logic [NS-1:0] byp2 = '0;
  logic [7:0]    addr2 = '0;
  logic [CW-1:0] data2 = '0;
  logic          ready2, gate2, busy2, done2, err2;
  coeffs_t       coeffs2;
  logic [NS-1:0] bypass2;

  int      tests = 0;
  int      fails = 0;
  coeffs_t m_shadow = '0;
  logic    m_err = 1'b0;
  exp_t    sb[$];

  always #5 clk = ~clk;

  ddc_cfg_ctrl #(.COEFF_WIDTH(CW), .N_COEFFS(NC), .N_STAGES(NS), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .cfg_valid_in(cfg_valid), .cfg_ready_out(ready),
    .cfg_commit_in(cfg_commit), .cfg_addr_in(cfg_addr), .cfg_data_in(cfg_data),
    .cfg_bypass_in(cfg_bypass), .coeffs_out(coeffs), .bypass_out(bypass),
    .gate_out(gate), .busy_out(busy), .done_out(done), .err_out(err)
  );

  ddc_cfg_ctrl #(.COEFF_WIDTH(CW), .N_COEFFS(NC), .N_STAGES(NS), .DRAIN_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .cfg_valid_in(v2), .cfg_ready_out(ready2),
    .cfg_commit_in(c2), .cfg_addr_in(addr2), .cfg_data_in(data2),
    .cfg_bypass_in(byp2), .coeffs_out(coeffs2), .bypass_out(bypass2),
    .gate_out(gate2), .busy_out(busy2), .done_out(done2), .err_out(err2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int st, input int idx, input logic [CW-1:0] d);
    cfg_valid = 1'b1; cfg_commit = 1'b0;
    cfg_addr = {2'(st), 6'(idx)}; cfg_data = d;
    tick();
    cfg_valid = 1'b0;
    if (st < NS && idx < NC) m_shadow[st][idx] = d;
    else m_err = 1'b1;
    tests++;
    if (err !== m_err) begin
      fails++; $display("FAIL write_err st=%0d idx=%0d got=%b exp=%b", st, idx, err, m_err);
    end
  endtask

  // Commit, check cycle-by-cycle gating, pop the scoreboard when done fires.
  task automatic do_commit(input logic [NS-1:0] byp, input bit hold_wr);
    exp_t e;
    bit   got;
    e.c = m_shadow; e.b = byp;
    sb.push_back(e);
    cfg_valid = 1'b1; cfg_commit = 1'b1; cfg_bypass = byp;
    tick();
    cfg_valid = 1'b0; cfg_commit = 1'b0;
    m_err = 1'b0;
    got = 1'b0;
    for (int k = 1; k <= DC + 10 && !got; k++) begin
      logic exp_gate;
      exp_gate = (k <= DC + 1);
      if (hold_wr && k == 3) begin
        cfg_valid = 1'b1; cfg_commit = 1'b0;
        cfg_addr = {2'd2, 6'd7}; cfg_data = 16'hABCD;
      end
      if (k == 1) begin
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL commit_err_clear got=%b exp=0", err); end
      end
      tests++;
      if (gate !== exp_gate || busy !== exp_gate) begin
        fails++; $display("FAIL gate_busy k=%0d gate=%b busy=%b exp=%b", k, gate, busy, exp_gate);
      end
      tests++;
      if (ready !== !exp_gate) begin
        fails++; $display("FAIL ready k=%0d got=%b exp=%b", k, ready, !exp_gate);
      end
      if (done === 1'b1) begin
        exp_t x;
        got = 1'b1;
        x = sb.pop_front();
        tests++;
        if (k != DC + 2) begin fails++; $display("FAIL done_cycle got=%0d exp=%0d", k, DC + 2); end
        tests++;
        if (coeffs !== x.c) begin fails++; $display("FAIL coeffs_after_swap got=%h exp=%h", coeffs[1][5], x.c[1][5]); end
        tests++;
        if (bypass !== x.b) begin fails++; $display("FAIL bypass_after_swap got=%b exp=%b", bypass, x.b); end
        if (hold_wr) begin
          tick();
          cfg_valid = 1'b0;
          m_shadow[2][7] = 16'hABCD;
          tests++;
          if (done !== 1'b0) begin fails++; $display("FAIL done_width got=%b exp=0", done); end
          tests++;
          if (coeffs[2][7] !== x.c[2][7]) begin
            fails++; $display("FAIL held_write_active got=%h exp=%h", coeffs[2][7], x.c[2][7]);
          end
        end
      end else begin
        tick();
      end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL done_timeout got=none exp=pulse at %0d", DC + 2);
      void'(sb.pop_front());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    tests++; if (coeffs !== '0) begin fails++; $display("FAIL reset_coeffs got=%h exp=0", coeffs[0][0]); end
    tests++; if (bypass !== 3'b111) begin fails++; $display("FAIL reset_bypass got=%b exp=111", bypass); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", ready); end
    tests++; if (busy !== 1'b0 || gate !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b%b exp=00", busy, gate); end
    tests++; if (done !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL reset_done_err got=%b%b exp=00", done, err); end
  endtask

  task automatic test_commit();
    write(1, 5, 16'h1234);
    write(0, 0, 16'h5555);
    write(2, 39, 16'h8001);
    tests++;
    if (coeffs !== '0) begin fails++; $display("FAIL active_before_commit got=%h exp=0", coeffs[1][5]); end
    do_commit(3'b010, 1'b0);
  endtask

  task automatic test_bad_addr();
    write(3, 0, 16'hFFFF);
    write(0, 45, 16'hEEEE);
    write(0, 40, 16'hDDDD);
    do_commit(3'b110, 1'b0);
  endtask

  task automatic test_ignore_in_drain();
    do_commit(3'b101, 1'b1);
    do_commit(3'b011, 1'b0);
  endtask

  task automatic test_back_to_back();
    write(1, 5, 16'h4321);
    do_commit(3'b100, 1'b0);
    do_commit(3'b001, 1'b0);
  endtask

  task automatic test_reset_mid_drain();
    bit seen;
    write(0, 3, 16'h0BAD);
    cfg_valid = 1'b1; cfg_commit = 1'b1; cfg_bypass = 3'b000;
    tick();
    cfg_valid = 1'b0; cfg_commit = 1'b0;
    for (int k = 1; k < 30; k++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    m_shadow = '0; m_err = 1'b0;
    tests++; if (gate !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL midrst_gate got=%b%b exp=00", gate, busy); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL midrst_ready got=%b exp=1", ready); end
    tests++; if (coeffs !== '0) begin fails++; $display("FAIL midrst_coeffs got=%h exp=0", coeffs[0][3]); end
    tests++; if (bypass !== 3'b111) begin fails++; $display("FAIL midrst_bypass got=%b exp=111", bypass); end
    seen = 1'b0;
    for (int k = 0; k < DC + 10; k++) begin
      if (done === 1'b1) seen = 1'b1;
      tick();
    end
    tests++; if (seen) begin fails++; $display("FAIL midrst_done got=pulse exp=none"); end
    do_commit(3'b011, 1'b0);
  endtask

  task automatic test_drain1();
    v2 = 1'b1; c2 = 1'b1; byp2 = 3'b100;
    tick();
    v2 = 1'b0; c2 = 1'b0;
    tests++; if (gate2 !== 1'b1 || done2 !== 1'b0) begin fails++; $display("FAIL d1_t1 gate=%b done=%b exp=1,0", gate2, done2); end
    tick();
    tests++; if (gate2 !== 1'b1 || done2 !== 1'b0) begin fails++; $display("FAIL d1_t2 gate=%b done=%b exp=1,0", gate2, done2); end
    tick();
    tests++; if (gate2 !== 1'b0 || done2 !== 1'b1) begin fails++; $display("FAIL d1_t3 gate=%b done=%b exp=0,1", gate2, done2); end
    tests++; if (bypass2 !== 3'b100) begin fails++; $display("FAIL d1_bypass got=%b exp=100", bypass2); end
    tick();
    tests++; if (done2 !== 1'b0) begin fails++; $display("FAIL d1_done_width got=%b exp=0", done2); end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_bad_addr();
    test_ignore_in_drain();
    test_back_to_back();
    test_reset_mid_drain();
    test_drain1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
